// File: rtl/iter_shift_unit_pkg.sv
// Shared types and helpers for the iterative shifter.
// SHIFT_ROTATE_EN: when defined, ROR/ROL are legal operations.
package shift_unit_pkg;

  typedef enum logic [2:0] {
    OP_SRL = 3'b000,
    OP_SLL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROR = 3'b011,
    OP_ROL = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_e;

  // Whether a raw SHIFT_FUN code names an implemented operation.
  function automatic logic op_legal(input logic [2:0] fun);
    logic ok;
    ok = 1'b0;
    case (fun)
      OP_SRL, OP_SLL, OP_SRA: ok = 1'b1;
`ifdef SHIFT_ROTATE_EN
      OP_ROR, OP_ROL:         ok = 1'b1;
`endif
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Number of single-bit positions actually shifted: rotates wrap modulo
  // the width, everything else saturates at the width.
  function automatic int unsigned eff_amount(input logic [2:0] fun,
                                             input int unsigned shamt,
                                             input int unsigned width);
`ifdef SHIFT_ROTATE_EN
    if (fun == OP_ROR || fun == OP_ROL) return shamt % width;
`endif
    return (shamt > width) ? width : shamt;
  endfunction

endpackage

// File: rtl/iter_shift_unit_if.sv
// Request/response bundle of the iterative shifter.
interface iter_shift_unit_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               SRC_SEL;
  logic [2:0]         SHIFT_FUN;
  logic [SHAMT_W-1:0] SHAMT;
  logic               IN_VALID;
  logic               IN_READY;
  logic [WIDTH-1:0]   SHIFT_OUT;
  logic               CARRY_OUT;
  logic               ERR;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic               SHIFT_Flag;

  modport master (
    output A, B, SRC_SEL, SHIFT_FUN, SHAMT, IN_VALID, OUT_READY,
    input  IN_READY, SHIFT_OUT, CARRY_OUT, ERR, OUT_VALID, SHIFT_Flag
  );

  modport slave (
    input  A, B, SRC_SEL, SHIFT_FUN, SHAMT, IN_VALID, OUT_READY,
    output IN_READY, SHIFT_OUT, CARRY_OUT, ERR, OUT_VALID, SHIFT_Flag
  );
endinterface

// File: rtl/iter_shift_unit_shift_step.sv
// One combinational step: shifts {carry,data} by k (0..STEP) bits.
// SHIFT_ROTATE_EN: when defined, the rotate paths are built.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH:0]   din,
  input  logic [KW-1:0]    k,
  input  shift_op_e        op,
  output logic [WIDTH:0]   dout
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] rsh1;
  logic [WIDTH-1:0] lsh1;

  assign d = din[WIDTH-1:0];
  // Shifted by k-1 so the last bit leaving the word sits at an edge.
  assign rsh1 = d >> (32'(k) - 32'd1);
  assign lsh1 = d << (32'(k) - 32'd1);

  // Select the per-op result; k == 0 passes the word through.
  always_comb begin
    dout = din;
    if (k != '0) begin
      case (op)
        OP_SRL: dout = {rsh1[0], rsh1 >> 1};
        OP_SRA: dout = {rsh1[0], WIDTH'($signed(d) >>> k)};
        OP_SLL: dout = {lsh1[WIDTH-1], lsh1 << 1};
`ifdef SHIFT_ROTATE_EN
        OP_ROR: dout = {rsh1[0], (d >> k) | (d << (WIDTH - 32'(k)))};
        OP_ROL: dout = {lsh1[WIDTH-1], (d << k) | (d >> (WIDTH - 32'(k)))};
`endif
        default: dout = din;
      endcase
    end
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter, STEP bits per clock, valid/ready on both sides.
// SHIFT_ROTATE_EN: when defined, ROR/ROL are implemented; otherwise illegal.
module iter_shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input logic              CLK,
  input logic              RST,
  iter_shift_unit_if.slave bus
);

  localparam int KW = $clog2(STEP + 1);

  shift_state_e       state_q, state_d;
  shift_op_e          op_q;
  logic [WIDTH-1:0]   data_q;
  logic               carry_q;
  logic               err_q;
  logic               over_q;
  logic [SHAMT_W-1:0] rem_q;

  logic [WIDTH-1:0]   operand;
  logic               legal;
  logic [SHAMT_W-1:0] eff;
  logic [KW-1:0]      k;
  logic               last_step;
  logic [WIDTH:0]     step_out;

  assign operand   = bus.SRC_SEL ? bus.B : bus.A;
  assign legal     = op_legal(bus.SHIFT_FUN);
  assign eff       = SHAMT_W'(eff_amount(bus.SHIFT_FUN, 32'(bus.SHAMT), WIDTH));
  assign k         = (rem_q < SHAMT_W'(STEP)) ? KW'(rem_q) : KW'(STEP);
  assign last_step = (rem_q <= SHAMT_W'(STEP));

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .din  ({carry_q, data_q}),
    .k    (k),
    .op   (op_q),
    .dout (step_out)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.IN_VALID) state_d = (!legal || eff == '0) ? DONE : SHIFT;
      SHIFT:   if (last_step)    state_d = DONE;
      DONE:    if (bus.OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and iterative shifting.
  // Amounts past WIDTH are saturated to WIDTH so latency stays bounded;
  // over_q restores the zero carry that SRL/SLL would have produced.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q    <= OP_SRL;
      data_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      over_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.IN_VALID) begin
            op_q    <= shift_op_e'(bus.SHIFT_FUN);
            data_q  <= legal ? operand : '0;
            carry_q <= 1'b0;
            err_q   <= !legal;
            over_q  <= (bus.SHIFT_FUN == OP_SRL || bus.SHIFT_FUN == OP_SLL) &&
                       (bus.SHAMT > SHAMT_W'(WIDTH));
            rem_q   <= eff;
          end
        end
        SHIFT: begin
          data_q  <= step_out[WIDTH-1:0];
          carry_q <= (last_step && over_q) ? 1'b0 : step_out[WIDTH];
          rem_q   <= rem_q - SHAMT_W'(k);
        end
        default: ;
      endcase
    end
  end

  assign bus.IN_READY   = (state_q == IDLE) && !RST;
  assign bus.OUT_VALID  = (state_q == DONE);
  assign bus.SHIFT_Flag = (state_q == SHIFT);
  assign bus.SHIFT_OUT  = data_q;
  assign bus.CARRY_OUT  = carry_q;
  assign bus.ERR        = err_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench: two shifters (STEP=1 and STEP=4) driven in lockstep.
// SHIFT_ROTATE_EN selects the rotate expectations.
module tb_iter_shift_unit;

  logic       clk;
  logic       rst;
  logic [7:0] a_r, b_r;
  logic       src_r;
  logic [2:0] fun_r;
  logic [3:0] shamt_r;
  logic       in_valid;
  logic       out_ready;

  int n_run  = 0;
  int n_fail = 0;

  iter_shift_unit_if #(.WIDTH(8)) bus1 ();
  iter_shift_unit_if #(.WIDTH(8)) bus4 ();

  assign bus1.A = a_r;       assign bus4.A = a_r;
  assign bus1.B = b_r;       assign bus4.B = b_r;
  assign bus1.SRC_SEL = src_r;     assign bus4.SRC_SEL = src_r;
  assign bus1.SHIFT_FUN = fun_r;   assign bus4.SHIFT_FUN = fun_r;
  assign bus1.SHAMT = shamt_r;     assign bus4.SHAMT = shamt_r;
  assign bus1.IN_VALID = in_valid; assign bus4.IN_VALID = in_valid;
  assign bus1.OUT_READY = out_ready; assign bus4.OUT_READY = out_ready;

  iter_shift_unit #(.WIDTH(8), .STEP(1)) u1 (.CLK(clk), .RST(rst), .bus(bus1));
  iter_shift_unit #(.WIDTH(8), .STEP(4)) u4 (.CLK(clk), .RST(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".rdy1"}, 32'(bus1.IN_READY), 0);
    check({tag, ".rdy4"}, 32'(bus4.IN_READY), 0);
    check({tag, ".ov1"},  32'(bus1.OUT_VALID), 0);
    check({tag, ".ov4"},  32'(bus4.OUT_VALID), 0);
    check({tag, ".fl1"},  32'(bus1.SHIFT_Flag), 0);
    check({tag, ".fl4"},  32'(bus4.SHIFT_Flag), 0);
    check({tag, ".out1"}, {bus1.ERR, bus1.CARRY_OUT, bus1.SHIFT_OUT}, 0);
    check({tag, ".out4"}, {bus4.ERR, bus4.CARRY_OUT, bus4.SHIFT_OUT}, 0);
  endtask

  // Issue one request and follow both units to OUT_VALID, counting
  // cycles and SHIFT_Flag cycles after acceptance.
  task automatic run_req(input string name, input logic src, input logic [2:0] fun,
                         input logic [3:0] shamt, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_out, input logic exp_c, input logic exp_e,
                         input int n1, input int n4);
    int  lat1, lat4, fl1, fl4;
    bit  d1, d4;
    lat1 = 0; lat4 = 0; fl1 = 0; fl4 = 0; d1 = 0; d4 = 0;
    @(negedge clk);
    check({name, ".ready1"}, 32'(bus1.IN_READY), 1);
    check({name, ".ready4"}, 32'(bus4.IN_READY), 1);
    src_r = src; fun_r = fun; shamt_r = shamt; a_r = a; b_r = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a_r = 8'h00; b_r = 8'h00; fun_r = 3'b000; shamt_r = 4'd0;
    for (int c = 0; c < 40 && !(d1 && d4); c++) begin
      if (!d1) begin
        if (bus1.OUT_VALID) begin
          d1 = 1;
          check({name, ".res1"}, {bus1.ERR, bus1.CARRY_OUT, bus1.SHIFT_OUT}, {exp_e, exp_c, exp_out});
        end else begin
          lat1++;
          fl1 += int'(bus1.SHIFT_Flag);
        end
      end
      if (!d4) begin
        if (bus4.OUT_VALID) begin
          d4 = 1;
          check({name, ".res4"}, {bus4.ERR, bus4.CARRY_OUT, bus4.SHIFT_OUT}, {exp_e, exp_c, exp_out});
        end else begin
          lat4++;
          fl4 += int'(bus4.SHIFT_Flag);
        end
      end
      if (!(d1 && d4)) @(negedge clk);
    end
    check({name, ".done1"}, 32'(d1), 1);
    check({name, ".done4"}, 32'(d4), 1);
    check({name, ".lat1"}, lat1, n1);
    check({name, ".lat4"}, lat4, n4);
    check({name, ".busy1"}, fl1, n1);
    check({name, ".busy4"}, fl4, n4);
    if (out_ready) begin
      @(negedge clk);
      check({name, ".drop1"}, {bus1.OUT_VALID, bus1.IN_READY}, 2'b01);
      check({name, ".drop4"}, {bus4.OUT_VALID, bus4.IN_READY}, 2'b01);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_r = '0; b_r = '0; src_r = 1'b0; fun_r = '0; shamt_r = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    run_req("srl3",    0, 3'b000, 4'd3,  8'hB5, 8'h00, 8'h16, 1, 0, 3, 1);
    run_req("sra9",    1, 3'b010, 4'd9,  8'h00, 8'h81, 8'hFF, 1, 0, 8, 2);
    run_req("sll8",    1, 3'b001, 4'd8,  8'h00, 8'h81, 8'h00, 1, 0, 8, 2);
    run_req("sll3",    0, 3'b001, 4'd3,  8'hB5, 8'h00, 8'hA8, 1, 0, 3, 1);
    run_req("sll12",   0, 3'b001, 4'd12, 8'hB5, 8'h00, 8'h00, 0, 0, 8, 2);
    run_req("srl8",    0, 3'b000, 4'd8,  8'hB5, 8'h00, 8'h00, 1, 0, 8, 2);
    run_req("sra5",    0, 3'b010, 4'd5,  8'hB5, 8'h00, 8'hFD, 1, 0, 5, 2);
    run_req("sra15",   0, 3'b010, 4'd15, 8'h35, 8'h00, 8'h00, 0, 0, 8, 2);
    run_req("illegal", 0, 3'b111, 4'd3,  8'h5A, 8'h00, 8'h00, 0, 1, 0, 0);
    run_req("zero",    0, 3'b001, 4'd0,  8'h5A, 8'h00, 8'h5A, 0, 0, 0, 0);
`ifdef SHIFT_ROTATE_EN
    run_req("rol11",   0, 3'b100, 4'd11, 8'h96, 8'h00, 8'hB4, 0, 0, 3, 1);
    run_req("ror5",    0, 3'b011, 4'd5,  8'h96, 8'h00, 8'hB4, 1, 0, 5, 2);
    run_req("ror8",    0, 3'b011, 4'd8,  8'h96, 8'h00, 8'h96, 0, 0, 0, 0);
`else
    run_req("rol11",   0, 3'b100, 4'd11, 8'h96, 8'h00, 8'h00, 0, 1, 0, 0);
    run_req("ror5",    0, 3'b011, 4'd5,  8'h96, 8'h00, 8'h00, 0, 1, 0, 0);
    run_req("ror8",    0, 3'b011, 4'd8,  8'h96, 8'h00, 8'h00, 0, 1, 0, 0);
`endif

    // Backpressure: result held, new request ignored while in DONE.
    out_ready = 1'b0;
    run_req("hold", 0, 3'b000, 4'd3, 8'hB5, 8'h00, 8'h16, 1, 0, 3, 1);
    fun_r = 3'b111; a_r = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold.st1", {bus1.IN_READY, bus1.OUT_VALID, bus1.ERR, bus1.CARRY_OUT, bus1.SHIFT_OUT},
            {4'b0101, 8'h16});
      check("hold.st4", {bus4.IN_READY, bus4.OUT_VALID, bus4.ERR, bus4.CARRY_OUT, bus4.SHIFT_OUT},
            {4'b0101, 8'h16});
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("release1", {bus1.OUT_VALID, bus1.IN_READY}, 2'b01);
    check("release4", {bus4.OUT_VALID, bus4.IN_READY}, 2'b01);
    @(negedge clk);
    check("quiet1", {bus1.OUT_VALID, bus1.SHIFT_Flag}, 2'b00);
    check("quiet4", {bus4.OUT_VALID, bus4.SHIFT_Flag}, 2'b00);

    // Reset in the middle of a shift discards the operation.
    src_r = 1'b0; fun_r = 3'b000; shamt_r = 4'd5; a_r = 8'hB5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid.busy1", 32'(bus1.SHIFT_Flag), 1);
    rst = 1'b1;
    #1;
    check("rst.rdy1", 32'(bus1.IN_READY), 0);
    check("rst.rdy4", 32'(bus4.IN_READY), 0);
    @(negedge clk);
    check_idle_zero("rstmid");
    rst = 1'b0;
    #1;
    check("post.rdy1", 32'(bus1.IN_READY), 1);
    check("post.rdy4", 32'(bus4.IN_READY), 1);
    run_req("after_rst", 0, 3'b001, 4'd3, 8'hB5, 8'h00, 8'hA8, 1, 0, 3, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
